bt_cmd_ctrl: RTL and testbench
==============================

// Module: bt_cmd_ctrl
// PURPOSE
//  Parametrised Bluetooth-module command controller; successor to the fixed 2-button BT interface.
//  Holds the BT module in command mode after reset, sends a configurable two-command init sequence,
//  then maps NUM_BTN active-low push buttons to command-ROM entries. Drives the external snd_cmd
//  block via send/cmd_start/cmd_len and consumes its resp_rcvd. Adds per-command response timeout
//  with retry, queuing of presses made while busy, and a sticky error flag.
// PARAMETERS
//  NUM_BTN     4   number of buttons / button commands (1..8)
//  STARTUP_W   17  width of power-up counter; cmd_n deasserts after 2^STARTUP_W-1 cycles
//  ADDR_W      5   width of cmd_start (command ROM byte address)
//  LEN_W       4   width of cmd_len
//  INIT0_START 0   ROM address of init command 0;  INIT0_LEN 6  its length
//  INIT1_START 6   ROM address of init command 1;  INIT1_LEN 10 its length
//  BTN_BASE    16  ROM address of button-0 command; button i at BTN_BASE+BTN_LEN*i
//  BTN_LEN     4   length of every button command
//  TIMEOUT_W   20  response timeout = 2^TIMEOUT_W-1 cycles per wait
//  MAX_RETRY   3   resends allowed per command before error
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous active-low reset
//  btn_n      in   NUM_BTN  raw active-low push buttons (asynchronous)
//  resp_rcvd  in   1        1-cycle pulse from snd_cmd: response from BT module received
//  send       out  1        1-cycle pulse: snd_cmd starts command at cmd_start/cmd_len
//  cmd_start  out  ADDR_W   command ROM start address, valid while send=1
//  cmd_len    out  LEN_W    command length in bytes, valid while send=1
//  cmd_n      out  1        BT module command-mode pin; 1 during power-up delay, then 0
//  busy       out  1        1 whenever state != IDLE
//  err        out  1        sticky: command failed after MAX_RETRY resends or boot timeout
//  pend_ovf   out  1        1-cycle pulse: press dropped because that button already pending
// BEHAVIOUR
//  Reset: send=0, cmd_start=0, cmd_len=0, cmd_n=1, busy=1, err=0, pend_ovf=0, pending=0, state PWRUP.
//  cmd_start/cmd_len are registered and hold their last value between sends (no latches).
//  Startup counter saturates at all-ones; cmd_n = ~&counter (goes 0 on the saturating cycle and stays).
//  Buttons: 2-FF synchroniser + edge register per bit; press = synced 1->0. Edge at input sampled on
//   clk edge k -> press pulse visible cycle k+2; send asserts at k+3 if IDLE.
//  pending[NUM_BTN-1:0]: press sets bit; bit cleared in the cycle its send pulses. Press on a bit
//   already set (and not clearing that cycle) -> dropped, pend_ovf=1 for one cycle.
//   Presses are latched in every state except ERR (ignored there).
//  FSM:
//   PWRUP : wait counter saturated -> BOOT.
//   BOOT  : wait resp_rcvd (module boot message) -> send INIT0 -> INIT0. Timeout -> ERR (no retry).
//   INIT0 : wait resp -> send INIT1 -> INIT1.   INIT1 : wait resp -> IDLE.
//   IDLE  : if pending!=0 send lowest-index pending button (start=BTN_BASE+BTN_LEN*i, len=BTN_LEN) -> CMD.
//   CMD   : wait resp -> IDLE (next pending may send the following cycle, not same cycle).
//   ERR   : err=1, send never asserts, stays until rst_n.
//  Timeout (INIT0/INIT1/CMD): wait counter cleared on every send; reaching all-ones with no resp ->
//   resend same cmd_start/cmd_len, retry count+1; timeout with retry count==MAX_RETRY -> ERR.
//   Retry count cleared on each new command.
//  resp_rcvd same cycle as timeout -> response wins. resp_rcvd in PWRUP/IDLE/ERR ignored.
//  Reset mid-command: everything returns to reset values; pending presses are lost.
// TESTING (STARTUP_W=4, TIMEOUT_W=4, MAX_RETRY=2, defaults otherwise)
//  1 Reset release -> cmd_n=1 for 15 cycles then 0; no send before first resp_rcvd.
//  2 resp x3 -> sends start=0/len=6 then 6/10; busy falls after third resp.
//  3 IDLE, btn_n[2] low -> send start=24 len=4 three cycles later; busy until resp.
//  4 During CMD press btn 3 then 1 -> after resp, send 20 (btn1) then after next resp send 28.
//  5 Press btn 1 twice while busy -> one pend_ovf pulse; only one btn1 send follows.
//  6 No resp after send -> resend each 15 cycles, twice; third timeout -> err=1, sends stop.

Source files
------------

// File: rtl/bt_cmd_ctrl.sv
// rtl/bt_cmd_ctrl.sv - Bluetooth module command controller with init sequence, button queue and retry
module bt_cmd_ctrl #(
  parameter int NUM_BTN     = 4,
  parameter int STARTUP_W   = 17,
  parameter int ADDR_W      = 5,
  parameter int LEN_W       = 4,
  parameter int INIT0_START = 0,
  parameter int INIT0_LEN   = 6,
  parameter int INIT1_START = 6,
  parameter int INIT1_LEN   = 10,
  parameter int BTN_BASE    = 16,
  parameter int BTN_LEN     = 4,
  parameter int TIMEOUT_W   = 20,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               resp_rcvd,
  output logic               send,
  output logic [ADDR_W-1:0]  cmd_start,
  output logic [LEN_W-1:0]   cmd_len,
  output logic               cmd_n,
  output logic               busy,
  output logic               err,
  output logic               pend_ovf
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_BOOT, S_INIT0, S_INIT1, S_IDLE, S_CMD, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [STARTUP_W-1:0] startup_q;
  logic [TIMEOUT_W-1:0] wait_q, wait_d, wait_inc;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 send_q, send_d;
  logic [ADDR_W-1:0]    start_q, start_d, sel_start;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [NUM_BTN-1:0]   pending_q, pending_d, clr, sel_oh, press, accept, ovf;
  logic [NUM_BTN-1:0]   sync1_q, sync2_q, hist_q;
  logic                 ovf_q;
  logic                 timeout, waiting, retry_exhausted;

  // Power-up delay counter; saturates so cmd_n stays low afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) startup_q <= '0;
    else if (!(&startup_q)) startup_q <= startup_q + 1'b1;
  end

  // Two-flop synchroniser plus history register for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      hist_q  <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign press   = hist_q & ~sync2_q;
  assign accept  = (state_q == S_ERR) ? '0 : press;
  assign waiting = (state_q == S_BOOT) || (state_q == S_INIT0) ||
                   (state_q == S_INIT1) || (state_q == S_CMD);
  assign wait_inc = wait_q + 1'b1;
  // Timeout fires on the edge where the wait count would reach all-ones
  assign timeout  = &wait_inc;
  assign retry_exhausted = (retry_q == RW'(MAX_RETRY));

  // Next-state, send decision, pending queue and wait/retry bookkeeping
  always_comb begin
    state_d   = state_q;
    send_d    = 1'b0;
    start_d   = start_q;
    len_d     = len_q;
    retry_d   = retry_q;
    clr       = '0;
    sel_start = '0;
    sel_oh    = '0;
    // Scan downward so the lowest-index pending button ends up selected
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_start = ADDR_W'(BTN_BASE + BTN_LEN * i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    case (state_q)
      S_PWRUP: if (&startup_q) state_d = S_BOOT;
      S_BOOT: begin
        if (resp_rcvd) begin
          send_d  = 1'b1;
          start_d = ADDR_W'(INIT0_START);
          len_d   = LEN_W'(INIT0_LEN);
          retry_d = '0;
          state_d = S_INIT0;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_INIT0, S_INIT1, S_CMD: begin
        if (resp_rcvd) begin
          if (state_q == S_INIT0) begin
            send_d  = 1'b1;
            start_d = ADDR_W'(INIT1_START);
            len_d   = LEN_W'(INIT1_LEN);
            retry_d = '0;
            state_d = S_INIT1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          if (retry_exhausted) begin
            state_d = S_ERR;
          end else begin
            send_d  = 1'b1;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (|pending_q) begin
          send_d  = 1'b1;
          start_d = sel_start;
          len_d   = LEN_W'(BTN_LEN);
          retry_d = '0;
          clr     = sel_oh;
          state_d = S_CMD;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    wait_d    = (send_d || !waiting) ? '0 : wait_inc;
    ovf       = accept & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | accept;
  end

  // State, command outputs and queue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PWRUP;
      wait_q    <= '0;
      retry_q   <= '0;
      send_q    <= 1'b0;
      start_q   <= '0;
      len_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retry_q   <= retry_d;
      send_q    <= send_d;
      start_q   <= start_d;
      len_q     <= len_d;
      pending_q <= pending_d;
      ovf_q     <= |ovf;
    end
  end

  assign send      = send_q;
  assign cmd_start = start_q;
  assign cmd_len   = len_q;
  assign cmd_n     = ~(&startup_q);
  assign busy      = (state_q != S_IDLE);
  assign err       = (state_q == S_ERR);
  assign pend_ovf  = ovf_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// tb/tb_bt_cmd_ctrl.sv - scoreboard testbench for bt_cmd_ctrl
module tb_bt_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_n;
  logic       resp_rcvd;
  logic       send;
  logic [4:0] cmd_start;
  logic [3:0] cmd_len;
  logic       cmd_n, busy, err, pend_ovf;

  typedef struct {
    int start;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   send_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sends_seen = 0;
  int   ovf_seen = 0;
  int   cyc = 0;

  bt_cmd_ctrl #(
    .STARTUP_W(4),
    .TIMEOUT_W(4),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .resp_rcvd(resp_rcvd),
    .send(send), .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_n(cmd_n),
    .busy(busy), .err(err), .pend_ovf(pend_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every send must match the oldest expected command
  always @(negedge clk) begin
    if (pend_ovf) ovf_seen++;
    if (send) begin
      sends_seen++;
      send_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious_send", int'(send), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cmd_start", int'(cmd_start), e.start);
        chk("cmd_len", int'(cmd_len), e.len);
      end
    end
  end

  task automatic push_exp(input int s, input int l);
    exp_t e;
    e.start = s;
    e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic pulse_resp();
    @(negedge clk) resp_rcvd = 1'b1;
    @(negedge clk) resp_rcvd = 1'b0;
  endtask

  task automatic press_btn(input int i, input int hold);
    @(negedge clk) btn_n[i] = 1'b0;
    repeat (hold) @(negedge clk);
    btn_n[i] = 1'b1;
  endtask

  task automatic wait_send(input string tag, input int target);
    for (int n = 0; n < 60 && sends_seen < target; n++) @(negedge clk);
    chk(tag, sends_seen, target);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_send"}, int'(send), 0);
    chk({pfx, "_start"}, int'(cmd_start), 0);
    chk({pfx, "_len"}, int'(cmd_len), 0);
    chk({pfx, "_cmd_n"}, int'(cmd_n), 1);
    chk({pfx, "_busy"}, int'(busy), 1);
    chk({pfx, "_err"}, int'(err), 0);
    chk({pfx, "_ovf"}, int'(pend_ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    int n, base, ovf0;
    rst_n = 1'b0;
    btn_n = 4'hF;
    resp_rcvd = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // 1: power-up delay, no send before boot response
    rst_n = 1'b1;
    n = 0;
    while (cmd_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_n_high_cycles", n, 15);
    repeat (2) @(negedge clk);
    chk("no_send_before_boot", sends_seen, 0);

    // 2: boot response then two init commands
    push_exp(0, 6);
    pulse_resp();
    wait_send("init0_send", 1);
    push_exp(6, 10);
    pulse_resp();
    wait_send("init1_send", 2);
    chk("busy_in_init1", int'(busy), 1);
    pulse_resp();
    @(negedge clk);
    chk("idle_after_init", int'(busy), 0);

    // 3: single press latency and command mapping
    push_exp(24, 4);
    @(negedge clk) btn_n[2] = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (send) break;
    end
    chk("btn2_latency", n, 4);
    btn_n[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_in_cmd", int'(busy), 1);
    pulse_resp();
    @(negedge clk);
    chk("idle_after_btn2", int'(busy), 0);

    // 4: two presses queued during a command are served lowest index first
    push_exp(16, 4);
    press_btn(0, 2);
    wait_send("btn0_send", 4);
    push_exp(20, 4);
    push_exp(28, 4);
    press_btn(3, 2);
    press_btn(1, 2);
    @(negedge clk);
    pulse_resp();
    wait_send("btn1_first", 5);
    pulse_resp();
    wait_send("btn3_second", 6);
    pulse_resp();
    @(negedge clk);
    chk("idle_after_queue", int'(busy), 0);

    // 5: repeated press of a pending button is dropped with one overflow pulse
    push_exp(16, 4);
    press_btn(0, 2);
    wait_send("btn0_again", 7);
    ovf0 = ovf_seen;
    push_exp(20, 4);
    press_btn(1, 2);
    press_btn(1, 2);
    repeat (2) @(negedge clk);
    chk("ovf_pulses", ovf_seen - ovf0, 1);
    pulse_resp();
    wait_send("btn1_once", 8);
    pulse_resp();
    repeat (20) @(negedge clk);
    chk("single_btn1_send", sends_seen, 8);
    chk("idle_after_ovf", int'(busy), 0);

    // 6: no response -> two resends at timeout spacing, then error
    base = send_cyc.size();
    push_exp(24, 4);
    push_exp(24, 4);
    push_exp(24, 4);
    press_btn(2, 2);
    wait_send("first_try", 9);
    wait_send("retry1", 10);
    wait_send("retry2", 11);
    if (send_cyc.size() >= base + 3) begin
      chk("retry1_spacing", send_cyc[base+1] - send_cyc[base], 15);
      chk("retry2_spacing", send_cyc[base+2] - send_cyc[base+1], 15);
    end
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("err_set", int'(err), 1);
    if (send_cyc.size() >= base + 3) chk("err_delay", cyc - send_cyc[base+2], 15);
    press_btn(0, 2);
    pulse_resp();
    repeat (20) @(negedge clk);
    chk("no_send_in_err", sends_seen, 11);
    chk("err_sticky", int'(err), 1);
    chk("busy_in_err", int'(busy), 1);
    chk("exp_q_drained", exp_q.size(), 0);

    // Reset from the error state
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("rst2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
